// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP           = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  // Byte address to SRAM word index.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction
endpackage

// File: rtl/mips_next_pc.sv
// Next-PC select: redirect beats stall, otherwise sequential +4 (wrapping).
module mips_next_pc
  import mips_if_pkg::*;
(
  input  logic            [XLEN-1:0] pc,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic            [XLEN-1:0] redirect_target,
  output logic            [XLEN-1:0] pc_nxt,
  output logic                       misalign_nxt
);
  always_comb begin
    pc_nxt       = pc + PC_STEP;
    misalign_nxt = 1'b0;
    if (redirect_valid) begin
      // Target is forced word-aligned; the dropped low bits are only reported.
      pc_nxt       = {redirect_target[XLEN-1:2], 2'b00};
      misalign_nxt = |redirect_target[1:0];
    end else if (stall) begin
      pc_nxt = pc;
    end
  end
endmodule

// File: rtl/mips_if_stage.sv
// MIPS IF stage: PC register, combinational SRAM address, IF/ID register, fetch counter.
module mips_if_stage
  import mips_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clka,
  input  logic            rstb,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] fetch_count,
  output logic            misalign
);
  logic [XLEN-1:0] pc, pc_nxt;
  logic            misalign_nxt;
  logic            load;
  if_id_t          if_id;

  mips_next_pc u_next_pc (
    .pc              (pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_nxt          (pc_nxt),
    .misalign_nxt    (misalign_nxt)
  );

  assign load      = !flush && !stall;
  assign imem_addr = word_addr(pc);

  always_ff @(posedge clka or negedge rstb) begin
    if (!rstb) begin
      pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      misalign    <= 1'b0;
      if_id       <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc4: '0};
      fetch_count <= '0;
    end else begin
      pc       <= pc_nxt;
      misalign <= misalign_nxt;
      // Flush keeps pc/pc4 so decode still sees where the bubble came from.
      if (flush) begin
        if_id.valid <= 1'b0;
        if_id.instr <= NOP_INSTR;
      end else if (load) begin
        if_id       <= '{valid: 1'b1, instr: imem_rdata, pc: pc, pc4: pc + PC_STEP};
        fetch_count <= fetch_count + 1'b1;
      end
    end
  end

  assign if_id_valid = if_id.valid;
  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign if_id_pc4   = if_id.pc4;
endmodule

// File: tb/tb_mips_if_stage.sv
// Bench for mips_if_stage: directed vector table, async-reset sequence, random run vs reference model.
module tb_mips_if_stage;
  logic        clka = 1'b0;
  logic        rstb;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clka = ~clka;

  // Instruction memory: a few fixed program words, hashed filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    case (widx)
      32'd0:   return 32'h3C08_0000;
      32'd1:   return 32'h2108_0005;
      32'd2:   return 32'h3C09_0000;
      32'd5:   return 32'h3C0B_09F0;
      32'd7:   return 32'hAD68_0000;
      default: return (widx * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  mips_if_stage dut (
    .clka            (clka),
    .rstb            (rstb),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc4       (if_id_pc4),
    .fetch_count     (fetch_count),
    .misalign        (misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic vld,
                         input logic [31:0] instr, input logic [31:0] ipc, input logic [31:0] ipc4,
                         input logic [31:0] cnt, input logic mis);
    chk({tag, ".imem_addr"},   imem_addr,   addr);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    chk({tag, ".if_id_instr"}, if_id_instr, instr);
    chk({tag, ".if_id_pc"},    if_id_pc,    ipc);
    chk({tag, ".if_id_pc4"},   if_id_pc4,   ipc4);
    chk({tag, ".fetch_count"}, fetch_count, cnt);
    chk({tag, ".misalign"},    {31'd0, misalign}, {31'd0, mis});
  endtask

  typedef struct {
    logic        stall, flush, rv;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr, ipc, ipc4, cnt;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] t,
                              input logic [31:0] a, input logic v, input logic [31:0] i,
                              input logic [31:0] p, input logic [31:0] p4, input logic [31:0] c,
                              input logic m);
    vec_t x;
    x.stall = s; x.flush = f; x.rv = r; x.tgt = t;
    x.addr = a; x.vld = v; x.instr = i; x.ipc = p; x.ipc4 = p4; x.cnt = c; x.mis = m;
    return x;
  endfunction

  // Reference model state (architectural view).
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_vld, m_mis;

  task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] t);
    if (f) begin
      m_vld = 1'b0; m_instr = 32'h0;
    end else if (!s) begin
      m_vld = 1'b1; m_instr = mem_word(m_pc / 4);
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_cnt = m_cnt + 1;
    end
    if (r) begin
      m_mis = (t % 4) != 0;
      m_pc  = t - (t % 4);
    end else begin
      m_mis = 1'b0;
      if (!s) m_pc = m_pc + 4;
    end
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = mk(0,0,0,32'h0,        32'd1,        1, 32'h3C08_0000, 32'h0, 32'h4, 1, 0);
    vt[1]  = mk(0,0,0,32'h0,        32'd2,        1, 32'h2108_0005, 32'h4, 32'h8, 2, 0);
    vt[2]  = mk(1,0,0,32'h0,        32'd2,        1, 32'h2108_0005, 32'h4, 32'h8, 2, 0);
    vt[3]  = mk(1,0,0,32'h0,        32'd2,        1, 32'h2108_0005, 32'h4, 32'h8, 2, 0);
    vt[4]  = mk(1,0,0,32'h0,        32'd2,        1, 32'h2108_0005, 32'h4, 32'h8, 2, 0);
    vt[5]  = mk(0,0,1,32'h14,       32'd5,        1, 32'h3C09_0000, 32'h8, 32'hC, 3, 0);
    vt[6]  = mk(0,0,0,32'h0,        32'd6,        1, 32'h3C0B_09F0, 32'h14, 32'h18, 4, 0);
    vt[7]  = mk(0,1,1,32'h1E,       32'd7,        0, 32'h0,         32'h14, 32'h18, 4, 1);
    vt[8]  = mk(0,0,0,32'h0,        32'd8,        1, 32'hAD68_0000, 32'h1C, 32'h20, 5, 0);
    vt[9]  = mk(1,1,1,32'h40,       32'h10,       0, 32'h0,         32'h1C, 32'h20, 5, 0);
    vt[10] = mk(0,0,0,32'h0,        32'h11,       1, mem_word(32'h10), 32'h40, 32'h44, 6, 0);
    vt[11] = mk(1,0,1,32'h81,       32'h20,       1, mem_word(32'h10), 32'h40, 32'h44, 6, 1);
    vt[12] = mk(0,0,1,32'hFFFF_FFFC,32'h3FFF_FFFF,1, mem_word(32'h20), 32'h80, 32'h84, 7, 0);
    vt[13] = mk(0,0,0,32'h0,        32'h0,        1, mem_word(32'h3FFF_FFFF), 32'hFFFF_FFFC, 32'h0, 8, 0);
    vt[14] = mk(0,0,0,32'h0,        32'h1,        1, 32'h3C08_0000, 32'h0, 32'h4, 9, 0);
    vt[15] = mk(0,1,0,32'h0,        32'h2,        0, 32'h0,         32'h0, 32'h4, 9, 0);

    rstb = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    #12;
    chk_all("reset", 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    rstb = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall = vt[i].stall; flush = vt[i].flush;
      redirect_valid = vt[i].rv; redirect_target = vt[i].tgt;
      @(posedge clka); #1;
      chk_all($sformatf("vec%0d", i), vt[i].addr, vt[i].vld, vt[i].instr,
              vt[i].ipc, vt[i].ipc4, vt[i].cnt, vt[i].mis);
    end

    // Asynchronous reset in the middle of a redirect cycle.
    stall = 0; flush = 0; redirect_valid = 1; redirect_target = 32'h100;
    #2 rstb = 1'b0;
    #1 chk_all("async_rst", 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clka);
    redirect_valid = 0; redirect_target = 0;
    rstb = 1'b1;
    @(posedge clka); #1;
    chk_all("restart", 32'h1, 1, 32'h3C08_0000, 32'h0, 32'h4, 32'h1, 0);

    // Randomized run against the reference model.
    m_pc = 32'h4; m_vld = 1; m_instr = 32'h3C08_0000; m_ipc = 0; m_ipc4 = 4; m_cnt = 1; m_mis = 0;
    for (int c = 0; c < 400; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 6) == 0);
      redirect_valid = ($urandom_range(0, 6) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                     : $urandom();
      model_edge(stall, flush, redirect_valid, redirect_target);
      @(posedge clka); #1;
      chk_all($sformatf("rnd%0d", c), m_pc / 4, m_vld, m_instr, m_ipc, m_ipc4, m_cnt, m_mis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_if_stage.md
Name: mips_if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the instruction SRAM wrapper and directly downstream-adjacent to decode.
- Holds the PC and drives a word address to the instruction memory, which returns read data combinationally in the same cycle.
- Registers the returned instruction into the IF/ID pipeline register with a valid bit.
- Handles stall, flush and branch/jump redirect from decode, and counts retired fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; bits [1:0] are ignored (forced 0).
- NOP_INSTR, 32'h0000_0000, value placed in if_id_instr when a bubble is inserted.

Ports:
- clka  in  1  clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- stall  in  1  hold the PC and IF/ID contents this cycle.
- flush  in  1  squash the IF/ID entry (bubble) at the next edge.
- redirect_valid  in  1  load the PC from redirect_target at the next edge.
- redirect_target  in  32  byte address of the branch/jump target.
- imem_addr  out  32  word address to the instruction SRAM, {2'b00, pc[31:2]}.
- imem_rdata  in  32  instruction returned for imem_addr in the same cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  fetched instruction.
- if_id_pc  out  32  byte PC of if_id_instr.
- if_id_pc4  out  32  if_id_pc + 4, modulo 2^32.
- fetch_count  out  32  number of valid instructions written into IF/ID.
- misalign  out  1  one-cycle pulse when an accepted redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rstb low, asynchronous, immediate effect): pc = RESET_PC & ~3, if_id_valid = 0, if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_pc4 = 0, fetch_count = 0, misalign = 0.
- First edge after reset release fetches from RESET_PC.
- imem_addr is purely combinational from pc; no registered read.
- Latency: the instruction at pc appears on if_id_instr one clock after pc is presented. Throughput is 1 instruction/cycle.
- PC update at each rising edge, in priority order:
  - redirect_valid: pc <= {redirect_target[31:2], 2'b00}. This overrides stall. misalign <= (redirect_target[1:0] != 0).
  - else stall: pc holds.
  - else: pc <= pc + 4. Wraps from 32'hFFFF_FFFC to 0 with no error.
- misalign is 0 on every edge where redirect_valid is 0.
- IF/ID update at each rising edge, in priority order:
  - flush: if_id_valid <= 0, if_id_instr <= NOP_INSTR. if_id_pc and if_id_pc4 hold. Flush overrides stall.
  - else stall: all IF/ID fields hold.
  - else: if_id_valid <= 1, if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_pc4 <= pc + 4.
- Delay slot: redirect alone does not squash IF/ID, so the instruction fetched in the redirect cycle (the delay slot) is captured. Decode asserts flush together with redirect when squashing is required.
- stall + redirect in the same cycle: the PC takes the target; IF/ID holds.
- fetch_count increments by 1 on every edge where IF/ID is loaded with a valid instruction (neither flush nor stall). It wraps at 2^32 and never saturates.
- Reset asserted mid-stream discards any in-flight redirect or stall; there is no pending state beyond the registers listed.
- No X propagation: every register has a reset value, and outputs are defined whenever rstb is low.

Decomposition:
- Package mips_if_pkg: RESET_PC default, NOP_INSTR, XLEN = 32, PC_STEP = 4, and a function for word-address conversion (byte to word index).
- One sub-module, mips_next_pc: combinational next-PC select (redirect / hold / +4) plus alignment masking and misalign detection.
- IF/ID register and fetch counter stay in the top-level module.

Test Plan:
- Reset release with memory words {3C080000, 21080005, 3C090000, ...}:
  - imem_addr = 0, 1, 2 on successive cycles.
  - if_id_instr = 32'h3C080000 then 32'h21080005, with if_id_pc = 0 then 4.
  - fetch_count reaches 2.
- Stall held 3 cycles while pc = 8:
  - pc stays 8 and IF/ID holds 21080005 / pc 4.
  - fetch_count is frozen.
  - After release, 3C090000 appears with if_id_pc = 8.
- redirect_valid with target 32'h0000_0014 while pc = 8, no flush:
  - IF/ID captures the instruction at 8 (delay slot).
  - Next imem_addr = 5; if_id_instr = 3C0B09F0 one cycle later.
- redirect + flush, target 32'h0000_001E:
  - misalign pulses 1 for one cycle and pc = 32'h1C.
  - if_id_valid = 0 with instr = 0.
  - Next valid instruction is AD680000 at pc 1C.
- stall + redirect + flush together: the PC takes the target and IF/ID becomes a bubble. Separately, pc = 32'hFFFF_FFFC with no stall wraps to 0 with if_id_pc4 = 0.
- rstb pulled low asynchronously mid-cycle during a redirect: all outputs return to their reset values immediately, and fetch restarts at RESET_PC after release.
